// File: rtl/gpio_serial_fifo_ctrl.sv
// GPIO serial port: TX/RX FIFOs, programmable bit-rate divider, start/stop framing
// and selectable bit order on a single bidirectional pin.
module gpio_serial_fifo_ctrl #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gpio_direction,
  input  logic             lsb_first,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             tx_full,
  output logic [ASIZE:0]   tx_level,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rx_empty,
  output logic [ASIZE:0]   rx_level,
  input  logic             gpio_in,
  output logic             serial_out,
  output logic             serial_oe,
  output logic [DSIZE-1:0] pin_status,
  output logic             tx_busy,
  output logic             frame_err,
  output logic             rx_ovf,
  input  logic             clr_flags
);
  localparam int DEPTH = 1 << ASIZE;
  localparam int IW    = (DSIZE > 2) ? $clog2(DSIZE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  // ---------------- TX FIFO ----------------
  logic [DSIZE-1:0] tx_mem [DEPTH];
  logic [ASIZE:0]   tx_wptr_q, tx_rptr_q;
  logic             tx_empty, tx_push, tx_pop;

  assign tx_level = tx_wptr_q - tx_rptr_q;
  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_level == (ASIZE+1)'(DEPTH));
  assign tx_push  = winc & ~tx_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q[ASIZE-1:0]] <= wdata;
  end

  // ---------------- TX engine ----------------
  state_e           tx_state_q, tx_state_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [IW-1:0]    tx_idx_q, tx_idx_d;
  logic [DSIZE-1:0] tx_sh_q, tx_sh_d;
  logic             tx_lsb_q, tx_lsb_d, tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == tx_div_q);
  assign tx_busy    = (tx_state_q != S_IDLE);
  assign serial_oe  = gpio_direction | tx_busy;

  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_idx_d   = tx_idx_q;
    tx_sh_d    = tx_sh_q;
    tx_lsb_d   = tx_lsb_q;
    tx_pop     = 1'b0;
    serial_out = 1'b1;
    case (tx_state_q)
      S_START: serial_out = 1'b0;
      S_DATA:  serial_out = tx_lsb_q ? tx_sh_q[0] : tx_sh_q[DSIZE-1];
      default: serial_out = 1'b1;
    endcase
    // Launch from IDLE or straight out of a finished stop bit, giving gap-free frames.
    if (!tx_empty && gpio_direction &&
        (tx_state_q == S_IDLE || (tx_state_q == S_STOP && tx_bit_end))) begin
      tx_pop     = 1'b1;
      tx_sh_d    = tx_mem[tx_rptr_q[ASIZE-1:0]];
      tx_div_d   = clk_div;
      tx_lsb_d   = lsb_first;
      tx_cnt_d   = '0;
      tx_state_d = S_START;
    end else if (tx_state_q != S_IDLE) begin
      tx_cnt_d = tx_cnt_q + 1'b1;
      if (tx_bit_end) begin
        tx_cnt_d = '0;
        case (tx_state_q)
          S_START: begin
            tx_idx_d   = '0;
            tx_state_d = S_DATA;
          end
          S_DATA: begin
            tx_sh_d = tx_lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
            tx_idx_d = tx_idx_q + 1'b1;
            if (tx_idx_q == IW'(DSIZE-1)) tx_state_d = S_STOP;
          end
          default: tx_state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= '0;
      tx_idx_q   <= '0;
      tx_sh_q    <= '0;
      tx_lsb_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_idx_q   <= tx_idx_d;
      tx_sh_q    <= tx_sh_d;
      tx_lsb_q   <= tx_lsb_d;
    end
  end

  // ---------------- RX engine ----------------
  logic             rx_meta_q, rx_sync_q, rx_prev_q, rx_armed;
  state_e           rx_state_q, rx_state_d;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [IW-1:0]    rx_idx_q, rx_idx_d;
  logic [DSIZE-1:0] rx_sh_q, rx_sh_d;
  logic             rx_lsb_q, rx_lsb_d, rx_done_q, rx_done_d, rx_ferr_set;

  assign rx_armed = ~gpio_direction & ~tx_busy;

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_div_d    = rx_div_q;
    rx_idx_d    = rx_idx_q;
    rx_sh_d     = rx_sh_q;
    rx_lsb_d    = rx_lsb_q;
    rx_done_d   = 1'b0;
    rx_ferr_set = 1'b0;
    if (!rx_armed) begin
      rx_state_d = S_IDLE;
    end else if (rx_state_q == S_IDLE) begin
      if (rx_prev_q && !rx_sync_q) begin
        rx_cnt_d   = clk_div >> 1;
        rx_div_d   = clk_div;
        rx_lsb_d   = lsb_first;
        rx_state_d = S_START;
      end
    end else if (rx_cnt_q != '0) begin
      rx_cnt_d = rx_cnt_q - 1'b1;
    end else begin
      rx_cnt_d = rx_div_q;
      case (rx_state_q)
        S_START: begin
          rx_idx_d   = '0;
          rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          rx_sh_d  = rx_lsb_q ? {rx_sync_q, rx_sh_q[DSIZE-1:1]} : {rx_sh_q[DSIZE-2:0], rx_sync_q};
          rx_idx_d = rx_idx_q + 1'b1;
          if (rx_idx_q == IW'(DSIZE-1)) rx_state_d = S_STOP;
        end
        default: begin
          rx_done_d   = rx_sync_q;
          rx_ferr_set = ~rx_sync_q;
          rx_state_d  = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= '0;
      rx_idx_q   <= '0;
      rx_sh_q    <= '0;
      rx_lsb_q   <= 1'b0;
      rx_done_q  <= 1'b0;
    end else begin
      rx_meta_q  <= gpio_in;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_idx_q   <= rx_idx_d;
      rx_sh_q    <= rx_sh_d;
      rx_lsb_q   <= rx_lsb_d;
      rx_done_q  <= rx_done_d;
    end
  end

  // ---------------- RX FIFO and status ----------------
  logic [DSIZE-1:0] rx_mem [DEPTH];
  logic [ASIZE:0]   rx_wptr_q, rx_rptr_q, rx_wptr_n, rx_rptr_n;
  logic [DSIZE-1:0] rdata_q, rdata_d, pin_status_q;
  logic             rx_full, rx_push, rx_pop, frame_err_q, rx_ovf_q;

  assign rx_level   = rx_wptr_q - rx_rptr_q;
  assign rx_empty   = (rx_wptr_q == rx_rptr_q);
  assign rx_full    = (rx_level == (ASIZE+1)'(DEPTH));
  assign rx_push    = rx_done_q & ~rx_full;
  assign rx_pop     = rinc & ~rx_empty;
  assign rx_wptr_n  = rx_wptr_q + {{ASIZE{1'b0}}, rx_push};
  assign rx_rptr_n  = rx_rptr_q + {{ASIZE{1'b0}}, rx_pop};
  assign rdata      = rdata_q;
  assign pin_status = pin_status_q;
  assign frame_err  = frame_err_q;
  assign rx_ovf     = rx_ovf_q;

  // Show-ahead head register: bypass the word being written when it becomes the head.
  always_comb begin
    rdata_d = rdata_q;
    if (rx_rptr_n != rx_wptr_n)
      rdata_d = (rx_push && rx_wptr_q == rx_rptr_n) ? rx_sh_q : rx_mem[rx_rptr_n[ASIZE-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr_q[ASIZE-1:0]] <= rx_sh_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wptr_q    <= '0;
      rx_rptr_q    <= '0;
      rdata_q      <= '0;
      pin_status_q <= '0;
      frame_err_q  <= 1'b0;
      rx_ovf_q     <= 1'b0;
    end else begin
      rx_wptr_q   <= rx_wptr_n;
      rx_rptr_q   <= rx_rptr_n;
      rdata_q     <= rdata_d;
      if (rx_done_q) pin_status_q <= rx_sh_q;
      frame_err_q <= (frame_err_q & ~clr_flags) | rx_ferr_set;
      rx_ovf_q    <= (rx_ovf_q & ~clr_flags) | (rx_done_q & rx_full);
    end
  end
endmodule

// File: tb/tb_gpio_serial_fifo_ctrl.sv
// Directed bench for gpio_serial_fifo_ctrl: TX/RX word scoreboards, framing,
// FIFO boundaries, sticky flags, direction changes and reset.
module tb_gpio_serial_fifo_ctrl;
  localparam int DSIZE = 8;
  localparam int ASIZE = 4;
  localparam int DIV_W = 8;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst, gpio_direction, lsb_first, winc, rinc, gpio_in, clr_flags;
  logic [DIV_W-1:0] clk_div;
  logic [DSIZE-1:0] wdata, rdata, pin_status;
  logic             tx_full, rx_empty, serial_out, serial_oe, tx_busy, frame_err, rx_ovf;
  logic [ASIZE:0]   tx_level, rx_level;

  gpio_serial_fifo_ctrl #(.DSIZE(DSIZE), .ASIZE(ASIZE), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .gpio_direction(gpio_direction), .lsb_first(lsb_first),
    .clk_div(clk_div), .winc(winc), .wdata(wdata), .tx_full(tx_full), .tx_level(tx_level),
    .rinc(rinc), .rdata(rdata), .rx_empty(rx_empty), .rx_level(rx_level), .gpio_in(gpio_in),
    .serial_out(serial_out), .serial_oe(serial_oe), .pin_status(pin_status), .tx_busy(tx_busy),
    .frame_err(frame_err), .rx_ovf(rx_ovf), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  logic [DSIZE-1:0] tx_exp[$];
  logic [DSIZE-1:0] rx_exp[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_write(input logic [DSIZE-1:0] w);
    winc  = 1'b1;
    wdata = w;
    if (tx_exp.size() < DEPTH) tx_exp.push_back(w);
    @(negedge clk);
    winc = 1'b0;
  endtask

  task automatic wait_start(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (serial_out === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Called on the first cycle of a start bit; returns on the last cycle of the stop bit.
  task automatic tx_frame(input int div, input bit lsb, output logic [DSIZE-1:0] w, output bit ok);
    logic v, bitv;
    ok = 1'b1;
    w  = '0;
    bitv = 1'b0;
    for (int b = 0; b < DSIZE + 2; b++) begin
      for (int c = 0; c <= div; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        v = serial_out;
        if (c == 0) bitv = v;
        else if (v !== bitv) ok = 1'b0;
        if (serial_oe !== 1'b1) ok = 1'b0;
      end
      if (b == 0 && bitv !== 1'b0) ok = 1'b0;
      else if (b == DSIZE + 1 && bitv !== 1'b1) ok = 1'b0;
      else if (b > 0 && b <= DSIZE) begin
        if (lsb) w[b-1] = bitv;
        else     w[DSIZE-b] = bitv;
      end
    end
  endtask

  task automatic send_frame(input logic [DSIZE-1:0] w, input int div, input bit lsb, input bit stop);
    for (int b = 0; b < DSIZE + 2; b++) begin
      if (b == 0)              gpio_in = 1'b0;
      else if (b == DSIZE + 1) gpio_in = stop;
      else                     gpio_in = lsb ? w[b-1] : w[DSIZE-b];
      repeat (div + 1) @(negedge clk);
    end
    gpio_in = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_rx_level(input int exp, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rx_level === (ASIZE+1)'(exp)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [DSIZE-1:0] w, r;
    bit ok, ok2, seen;

    rst = 1'b1; gpio_direction = 1'b0; lsb_first = 1'b1; clk_div = '0;
    winc = 1'b0; wdata = '0; rinc = 1'b0; gpio_in = 1'b1; clr_flags = 1'b0;
    cyc(3);
    check("rst_serial_out", serial_out, 1);
    check("rst_serial_oe", serial_oe, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_tx_full", tx_full, 0);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_tx_level", tx_level, 0);
    check("rst_rx_level", rx_level, 0);
    check("rst_rdata", rdata, 0);
    check("rst_pin_status", pin_status, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_rx_ovf", rx_ovf, 0);
    rst = 1'b0;
    cyc(1);

    // TX single word, LSB first, 4 cycles per bit
    gpio_direction = 1'b1; clk_div = 8'd3; lsb_first = 1'b1;
    tx_write(8'hA5);
    check("tx1_level_n1", tx_level, 1);
    check("tx1_idle_n1", serial_out, 1);
    @(negedge clk);
    check("tx1_start_n2", serial_out, 0);
    check("tx1_busy_n2", tx_busy, 1);
    check("tx1_popped", tx_level, 0);
    tx_frame(3, 1'b1, w, ok);
    check("tx1_framing", ok, 1);
    check("tx1_word", w, tx_exp.pop_front());
    @(negedge clk);
    check("tx1_busy_end", tx_busy, 0);
    check("tx1_line_idle", serial_out, 1);

    // TX fill to full with direction=0, then drain back-to-back MSB first
    gpio_direction = 1'b0; clk_div = 8'd0; lsb_first = 1'b0;
    for (int i = 0; i < DEPTH; i++) tx_write(8'(8'h10 + i * 37));
    check("txf_full", tx_full, 1);
    check("txf_level16", tx_level, 16);
    check("txf_oe_off", serial_oe, 0);
    tx_write(8'hEE);
    check("txf_17th_level", tx_level, 16);
    check("txf_17th_full", tx_full, 1);
    gpio_direction = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 0) begin
        wait_start(4, ok);
        check("txf_first_start", ok, 1);
      end else begin
        @(negedge clk);
        check("txf_no_gap", serial_out, 0);
      end
      tx_frame(0, 1'b0, w, ok);
      check("txf_framing", ok, 1);
      check("txf_word", w, tx_exp.pop_front());
    end
    @(negedge clk);
    check("txf_busy_end", tx_busy, 0);
    check("txf_level_end", tx_level, 0);

    // RX loopback 0x3C MSB first, then a short glitch
    gpio_direction = 1'b0; clk_div = 8'd7; lsb_first = 1'b0;
    cyc(2);
    rx_exp.push_back(8'h3C);
    send_frame(8'h3C, 7, 1'b0, 1'b1);
    wait_rx_level(1, 20, ok);
    check("rx1_push_seen", ok, 1);
    check("rx1_rdata", rdata, rx_exp[0]);
    check("rx1_pin_status", pin_status, 8'h3C);
    check("rx1_not_empty", rx_empty, 0);
    check("rx1_frame_err", frame_err, 0);
    check("rx1_ovf", rx_ovf, 0);
    gpio_in = 1'b0;
    cyc(2);
    gpio_in = 1'b1;
    cyc(20);
    check("rx_glitch_level", rx_level, 1);
    r = rx_exp.pop_front();
    rinc = 1'b1;
    @(negedge clk);
    rinc = 1'b0;
    check("rx1_empty_after_read", rx_empty, 1);
    check("rx1_rdata_hold", rdata, r);
    rinc = 1'b1;
    @(negedge clk);
    rinc = 1'b0;
    check("rx_read_empty_hold", rdata, r);
    check("rx_read_empty_level", rx_level, 0);

    // RX frame error
    clk_div = 8'd3; lsb_first = 1'b1;
    send_frame(8'h81, 3, 1'b1, 1'b0);
    cyc(2);
    check("ferr_set", frame_err, 1);
    check("ferr_no_push", rx_level, 0);
    check("ferr_pin_hold", pin_status, 8'h3C);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    check("ferr_cleared", frame_err, 0);

    // RX fill and overflow
    clk_div = 8'd1; lsb_first = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      w = 8'($urandom_range(0, 255));
      if (rx_exp.size() < DEPTH) rx_exp.push_back(w);
      send_frame(w, 1, 1'b1, 1'b1);
    end
    wait_rx_level(16, 20, ok);
    check("ovf_fill16", ok, 1);
    check("ovf_not_yet", rx_ovf, 0);
    if (rx_exp.size() < DEPTH) rx_exp.push_back(8'h55);
    send_frame(8'h55, 1, 1'b1, 1'b1);
    cyc(4);
    check("ovf_set", rx_ovf, 1);
    check("ovf_pin_status", pin_status, 8'h55);
    check("ovf_level", rx_level, 16);
    check("ovf_head", rdata, rx_exp[0]);

    // clr_flags held while a new frame error arrives: set must win
    clr_flags = 1'b1;
    seen = 1'b0;
    fork
      send_frame(8'h0F, 1, 1'b1, 1'b0);
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (frame_err === 1'b1) begin
            clr_flags = 1'b0;
            seen = 1'b1;
            break;
          end
        end
      end
    join
    clr_flags = 1'b0;
    check("clr_vs_set_seen", seen, 1);
    cyc(2);
    check("clr_vs_set_stays", frame_err, 1);
    check("clr_ovf_cleared", rx_ovf, 0);
    check("clr_no_push", rx_level, 16);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_word", rdata, rx_exp.pop_front());
      rinc = 1'b1;
      @(negedge clk);
      rinc = 1'b0;
    end
    check("drain_empty", rx_empty, 1);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;

    // Direction rises mid-RX: abort, no push, no flag
    clk_div = 8'd7; lsb_first = 1'b0;
    fork
      send_frame(8'h77, 7, 1'b0, 1'b1);
      begin
        cyc(30);
        gpio_direction = 1'b1;
      end
    join
    cyc(10);
    check("dir_rx_no_push", rx_level, 0);
    check("dir_rx_pin_hold", pin_status, 8'h55);
    check("dir_rx_no_ferr", frame_err, 0);
    gpio_direction = 1'b0;
    cyc(2);

    // Direction falls mid-TX: frame completes, then output enable drops
    gpio_direction = 1'b1; clk_div = 8'd3; lsb_first = 1'b1;
    tx_write(8'h5A);
    wait_start(4, ok);
    check("dir_tx_start", ok, 1);
    fork
      tx_frame(3, 1'b1, w, ok2);
      begin
        cyc(15);
        gpio_direction = 1'b0;
        @(negedge clk);
        check("dir_tx_oe_hold", serial_oe, 1);
      end
    join
    check("dir_tx_framing", ok2, 1);
    check("dir_tx_word", w, tx_exp.pop_front());
    @(negedge clk);
    check("dir_tx_oe_off", serial_oe, 0);
    check("dir_tx_busy_off", tx_busy, 0);

    // Reset mid-TX frame with a word still queued
    gpio_direction = 1'b1;
    tx_write(8'hC3);
    tx_write(8'h11);
    wait_start(4, ok);
    check("rst_tx_start", ok, 1);
    cyc(10);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_serial_out", serial_out, 1);
    check("rst_mid_tx_level", tx_level, 0);
    check("rst_mid_tx_busy", tx_busy, 0);
    rst = 1'b0;
    gpio_direction = 1'b0;
    tx_exp.delete();
    cyc(3);
    check("rst_after_oe", serial_oe, 0);
    check("rst_after_line", serial_out, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
